uart_param: RTL
===============

UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL provide parameter DATA_BITS, default 8, legal range 5..9, frame payload width.
REQ-004 SHALL provide parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 SHALL provide parameter PARITY_ODD, default 0; 0 = even, 1 = odd; used only under UART_PARITY_EN.
REQ-006 SHALL provide port clk_50m  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL provide port din  input  DATA_BITS  transmit data.
REQ-009 SHALL provide port wr_en  input  1  transmit request, single-cycle strobe.
REQ-010 SHALL provide port tx  output  1  serial line out, idle high.
REQ-011 SHALL provide port tx_busy  output  1  transmitter occupied.
REQ-012 SHALL provide port rx  input  1  asynchronous serial line in.
REQ-013 SHALL provide port rdy  output  1  received word valid.
REQ-014 SHALL provide port rdy_clr  input  1  consumer acknowledge, clears rdy and error flags.
REQ-015 SHALL provide port dout  output  DATA_BITS  last received word.
REQ-016 SHALL provide ports frame_err, parity_err, overrun  output  1 each  sticky receive status.

Function
REQ-017 SHALL derive a 16x oversample tick every round(CLK_HZ/(BAUD*16)) clocks; one bit period = 16 ticks.
REQ-018 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; frame order start(0), data LSB first, parity, STOP_BITS stop(1).
REQ-019 wr_en in IDLE SHALL latch din and assert tx_busy the following cycle; wr_en while tx_busy=1 SHALL be ignored, no queueing.
REQ-020 tx_busy SHALL deassert in the cycle after the last stop bit period ends; back-to-back wr_en then yields zero idle gap.
REQ-021 RX SHALL pass rx through a 2-flop synchroniser before any use.
REQ-022 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; a synchronised falling edge in IDLE enters START.
REQ-023 START SHALL resample at tick 8; line high there = false start, return to IDLE, no flags change.
REQ-024 Each data/parity/stop bit SHALL be sampled once at its tick 8 (mid-bit); only the first stop bit is checked.
REQ-025 Stop sample 0 SHALL set frame_err; word still delivered to dout and rdy.
REQ-026 rdy and dout SHALL update in the cycle after the stop sample; rdy holds until rdy_clr.
REQ-027 Word completing while rdy=1 SHALL overwrite dout and set overrun.
REQ-028 rdy_clr coinciding with word completion SHALL leave rdy=1 with new dout; new-word flags win over clear.
REQ-029 rdy_clr SHALL clear frame_err, parity_err, overrun along with rdy.
REQ-030 TX and RX SHALL be fully independent; simultaneous operation (loopback) SHALL be supported.

Reset
REQ-031 rst_n low SHALL asynchronously force tx=1, tx_busy=0, rdy=0, dout=0, all error flags 0, both FSMs to IDLE, baud counter 0.
REQ-032 Reset mid-frame SHALL abort the frame; tx high from reset assertion; partial RX word discarded.
REQ-033 After rst_n release, RX SHALL ignore the line until it has been sampled high for one full bit period.

Configuration
REQ-034 Macro UART_PARITY_EN defined: PARITY state present in both FSMs, parity per PARITY_ODD, mismatch sets parity_err.
REQ-035 Macro UART_PARITY_EN undefined: PARITY states skipped, no parity bit on line, parity_err tied 0.

Structure
REQ-036 Package uart_pkg SHALL hold the shared FSM state typedef, OVERSAMPLE=16 constant, and mid-bit sample index constant.
REQ-037 Baud/oversample tick generation SHALL be sub-module uart_baud_gen, one instance shared by TX and RX.

Verification
REQ-038 Loopback, defaults, send 0xA5 -> rdy=1, dout=0xA5, all error flags 0, tx_busy low before rdy rises.
REQ-039 UART_PARITY_EN, even, send 0x07 -> parity bit on tx = 1; force received parity bit 0 -> parity_err=1, dout=0x07.
REQ-040 Drive frame 0x3C with stop bit 0 -> frame_err=1, rdy=1, dout=0x3C; rdy_clr pulse -> all cleared next cycle.
REQ-041 rx low pulse of 3 bit-sixteenths -> no rdy, FSM back in IDLE, flags 0.
REQ-042 Receive 0x11 then 0x22 without rdy_clr -> dout=0x22, overrun=1.
REQ-043 Assert rst_n low mid-transmit of 0xFF -> tx=1, tx_busy=0 immediately; subsequent send 0x55 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM state type and oversampling constants
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running 16x oversample tick generator
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parameterised UART TX/RX; parity bit present when UART_PARITY_EN is defined
module uart_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic                 rdy,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    logic tick;

    uart_baud_gen #(.DIV(baud_div(CLK_HZ, BAUD))) u_baud_gen (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .tick  (tick)
    );

    uart_state_t          tx_state, tx_state_nx;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;
    logic [3:0]           tx_tick_cnt, tx_bit_cnt;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_tick_cnt == 4'(OVERSAMPLE - 1));
    assign tx_busy    = (tx_state != IDLE);

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            IDLE:   if (wr_en) tx_state_nx = START;
            START:  if (tx_bit_end) tx_state_nx = DATA;
            DATA: begin
                if (tx_bit_end && tx_bit_cnt == 4'(DATA_BITS - 1)) begin
                    if (PARITY_EN) tx_state_nx = PARITY;
                    else           tx_state_nx = STOP;
                end
            end
            PARITY: if (tx_bit_end) tx_state_nx = STOP;
            STOP:   if (tx_bit_end && tx_bit_cnt == 4'(STOP_BITS - 1)) tx_state_nx = IDLE;
            default: tx_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= IDLE;
            tx_shreg    <= '0;
            tx_par      <= 1'b0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx          <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            if (tx_state == IDLE) begin
                tx_tick_cnt <= '0;
                tx_bit_cnt  <= '0;
                if (wr_en) begin
                    tx_shreg <= din;
                    tx_par   <= (^din) ^ PAR_ODD;
                end
            end else begin
                if (tick) tx_tick_cnt <= tx_tick_cnt + 4'd1;
                if (tx_state_nx != tx_state) tx_bit_cnt <= '0;
                else if (tx_bit_end)         tx_bit_cnt <= tx_bit_cnt + 4'd1;
                if (tx_state == DATA && tx_bit_end) tx_shreg <= tx_shreg >> 1;
            end
            // Line is registered so it cannot glitch between state decodes.
            case (tx_state)
                START:   tx <= 1'b0;
                DATA:    tx <= tx_shreg[0];
                PARITY:  tx <= tx_par;
                default: tx <= 1'b1;
            endcase
        end
    end

    uart_state_t          rx_state, rx_state_nx;
    logic                 rx_s1, rx_s2, rx_prev, rx_armed;
    logic [3:0]           rx_tick_cnt, rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_par_bad, par_err_q;
    logic                 rx_fall, rx_mid, rx_done;

    assign rx_fall = rx_armed && rx_prev && !rx_s2;
    // START resamples half a bit after the edge; later bits are one full bit apart.
    assign rx_mid  = tick && (rx_tick_cnt == ((rx_state == START) ? 4'(MID_SAMPLE - 1)
                                                                   : 4'(OVERSAMPLE - 1)));
    assign rx_done = (rx_state == STOP) && rx_mid;
    assign parity_err = par_err_q;

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            IDLE: if (rx_fall) rx_state_nx = START;
            START: begin
                if (rx_mid) begin
                    if (rx_s2) rx_state_nx = IDLE;
                    else       rx_state_nx = DATA;
                end
            end
            DATA: begin
                if (rx_mid && rx_bit_cnt == 4'(DATA_BITS - 1)) begin
                    if (PARITY_EN) rx_state_nx = PARITY;
                    else           rx_state_nx = STOP;
                end
            end
            PARITY: if (rx_mid) rx_state_nx = STOP;
            STOP:   if (rx_mid) rx_state_nx = IDLE;
            default: rx_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_armed    <= 1'b0;
            rx_state    <= IDLE;
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shreg    <= '0;
            rx_par_bad  <= 1'b0;
            rdy         <= 1'b0;
            dout        <= '0;
            frame_err   <= 1'b0;
            par_err_q   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_nx;
            if (rx_state_nx != rx_state) begin
                rx_tick_cnt <= '0;
                rx_bit_cnt  <= '0;
            end else begin
                if (rx_state == IDLE && !rx_s2) rx_tick_cnt <= '0;
                else if (tick)                  rx_tick_cnt <= rx_tick_cnt + 4'd1;
                if (rx_mid) rx_bit_cnt <= rx_bit_cnt + 4'd1;
            end
            // Arm only after a full bit period of idle-high line following reset.
            if (rx_state == IDLE && !rx_armed && tick && rx_s2 &&
                rx_tick_cnt == 4'(OVERSAMPLE - 1))
                rx_armed <= 1'b1;
            if (rx_state == IDLE && rx_fall) rx_par_bad <= 1'b0;
            if (rx_state == DATA && rx_mid) rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
            if (rx_state == PARITY && rx_mid)
                rx_par_bad <= rx_s2 ^ (^rx_shreg) ^ PAR_ODD;
            if (rx_done) begin
                dout      <= rx_shreg;
                rdy       <= 1'b1;
                frame_err <= !rx_s2 || (frame_err && !rdy_clr);
                par_err_q <= (PARITY_EN && rx_par_bad) || (par_err_q && !rdy_clr);
                overrun   <= rdy || (overrun && !rdy_clr);
            end else if (rdy_clr) begin
                rdy       <= 1'b0;
                frame_err <= 1'b0;
                par_err_q <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end
endmodule
